multi_ch_frontend_cal: RTL

- Parametrised successor to the single-channel IR/RED front-end controller.
- Calibrates N_CH LED channels in sequence. For each channel it finds the DC-compensation DAC code by successive approximation, verifies it, then finds the largest PGA gain that keeps the ADC inside a guard window.
- After calibration it time-multiplexes the channels and emits tagged ADC samples.
- Sits between the analog front-end (LED drivers, DC-comp DAC, PGA, ADC) and the downstream sample processing.

---
 rtl/multi_ch_frontend_cal_if.sv | 43 ++++
 rtl/multi_ch_frontend_cal.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_frontend_cal_if.sv
// Front-end bundle between the calibration controller and the analog front-end / sample sink.
// master: the side that drives Find_Setting and ADC (front-end model or system).
// slave : the calibration controller.
//   Find_Setting  start/restart request (level, edge-detected by the controller)
//   ADC           unsigned ADC sample
//   LED           one-hot LED enable
//   DC_Comp       DC-compensation DAC code
//   PGA_Gain      PGA gain code
//   busy          calibration in progress
//   cal_done      calibration complete, run mode active
//   cal_fail      per-channel DC-verify failure flags
//   sample_valid  one-cycle run-mode sample strobe
//   sample_ch     channel tag of the sample
//   sample_data   captured ADC value
interface multi_ch_frontend_cal_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADC_W  = 8,
  parameter int unsigned DAC_W  = 7,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic              Find_Setting;
  logic [ADC_W-1:0]  ADC;
  logic [N_CH-1:0]   LED;
  logic [DAC_W-1:0]  DC_Comp;
  logic [GAIN_W-1:0] PGA_Gain;
  logic              busy;
  logic              cal_done;
  logic [N_CH-1:0]   cal_fail;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_ch;
  logic [ADC_W-1:0]  sample_data;

  modport master (
    output Find_Setting, ADC,
    input  LED, DC_Comp, PGA_Gain, busy, cal_done, cal_fail, sample_valid, sample_ch, sample_data
  );

  modport slave (
    input  Find_Setting, ADC,
    output LED, DC_Comp, PGA_Gain, busy, cal_done, cal_fail, sample_valid, sample_ch, sample_data
  );
endinterface

// File: rtl/multi_ch_frontend_cal.sv
// Multi-channel LED front-end calibration controller.
// For each channel in turn: successive-approximation search of the DC-compensation code,
// a verify sample against a tolerance around mid-scale, then a PGA gain ramp that stops at
// the largest gain keeping the ADC inside a guard window. Afterwards the channels are
// time-multiplexed and one tagged ADC sample is emitted per dwell slot.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   fe_io  front-end bundle (slave view): Find_Setting/ADC in; LED, DC_Comp, PGA_Gain,
//          busy, cal_done, cal_fail, sample_valid, sample_ch, sample_data out
module multi_ch_frontend_cal #(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned ADC_W         = 8,
  parameter int unsigned DAC_W         = 7,
  parameter int unsigned GAIN_W        = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TOL           = 3,
  parameter int unsigned GUARD         = 32,
  parameter int unsigned DWELL_CYCLES  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_ch_frontend_cal_if.slave fe_io
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BIT_W   = (DAC_W > 1) ? $clog2(DAC_W) : 1;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SettleLd = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DwellLd  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ADC_W:0]   MidX     = (ADC_W+1)'((2 ** (ADC_W - 1)) - 1);
  localparam logic [ADC_W:0]   TolX     = (ADC_W+1)'(TOL);
  localparam logic [ADC_W:0]   WinLoX   = (ADC_W+1)'(GUARD);
  localparam logic [ADC_W:0]   WinHiX   = (ADC_W+1)'((2 ** ADC_W) - 1 - GUARD);
  localparam logic [BIT_W-1:0] BitMsb   = BIT_W'(DAC_W - 1);
  localparam logic [DAC_W-1:0] DacMsb   = DAC_W'(1) << (DAC_W - 1);
  localparam logic [CH_W-1:0]  ChLast   = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  LedCh0   = N_CH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDcSar,
    StDcVerify,
    StPgaStep,
    StNextCh,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DAC_W-1:0]  dac_q, dac_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [N_CH-1:0]   led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_CH-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DAC_W-1:0]  dc_mem_q [N_CH];
  logic [DAC_W-1:0]  dc_mem_d [N_CH];
  logic [GAIN_W-1:0] gain_mem_q [N_CH];
  logic [GAIN_W-1:0] gain_mem_d [N_CH];
  logic              fs_q, fs_prev_q;

  logic              fs_rise;
  logic              settled;
  logic [ADC_W:0]    adc_x;
  logic [ADC_W:0]    abs_dev;
  logic              in_win;
  logic              sample_valid_c;
  logic [DAC_W-1:0]  sar_code;
  logic [GAIN_W-1:0] gain_dn;
  logic [CH_W-1:0]   ch_nxt;

  assign fs_rise = fs_q & ~fs_prev_q;
  assign settled = (cnt_q == '0);
  assign adc_x   = {1'b0, fe_io.ADC};
  assign abs_dev = (adc_x > MidX) ? (adc_x - MidX) : (MidX - adc_x);
  assign in_win  = (adc_x >= WinLoX) && (adc_x <= WinHiX);

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    bit_d          = bit_q;
    dac_d          = dac_q;
    gain_d         = gain_q;
    led_d          = led_q;
    busy_d         = busy_q;
    done_d         = done_q;
    fail_d         = fail_q;
    cnt_d          = settled ? cnt_q : (cnt_q - CNT_W'(1));
    dc_mem_d       = dc_mem_q;
    gain_mem_d     = gain_mem_q;
    sample_valid_c = 1'b0;
    // A higher DAC code lowers the ADC, so the trial bit survives only while still above MID.
    sar_code       = (adc_x > MidX) ? dac_q : (dac_q & ~(DAC_W'(1) << bit_q));
    gain_dn        = (gain_q == '0) ? '0 : (gain_q - GAIN_W'(1));
    ch_nxt         = (ch_q == ChLast) ? '0 : (ch_q + CH_W'(1));

    if (fs_rise) begin
      // Restart from any state; also suppresses a coinciding run-mode sample.
      state_d = StDcSar;
      ch_d    = '0;
      bit_d   = BitMsb;
      dac_d   = DacMsb;
      gain_d  = '0;
      led_d   = LedCh0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      fail_d  = '0;
      cnt_d   = SettleLd;
    end else begin
      case (state_q)
        StIdle: ;
        StDcSar: begin
          if (settled) begin
            cnt_d = SettleLd;
            if (bit_q == '0) begin
              dac_d   = sar_code;
              state_d = StDcVerify;
            end else begin
              bit_d = bit_q - BIT_W'(1);
              dac_d = sar_code | (DAC_W'(1) << (bit_q - BIT_W'(1)));
            end
          end
        end
        StDcVerify: begin
          if (settled) begin
            if (abs_dev > TolX) fail_d[ch_q] = 1'b1;
            dc_mem_d[ch_q] = dac_q;
            gain_d         = '0;
            cnt_d          = SettleLd;
            state_d        = StPgaStep;
          end
        end
        StPgaStep: begin
          if (settled) begin
            if (!in_win) begin
              gain_mem_d[ch_q] = gain_dn;
              gain_d           = gain_dn;
              state_d          = StNextCh;
            end else if (gain_q == '1) begin
              gain_mem_d[ch_q] = gain_q;
              state_d          = StNextCh;
            end else begin
              gain_d = gain_q + GAIN_W'(1);
              cnt_d  = SettleLd;
            end
          end
        end
        StNextCh: begin
          if (ch_q == ChLast) begin
            state_d = StRun;
            ch_d    = '0;
            led_d   = LedCh0;
            dac_d   = dc_mem_q[0];
            gain_d  = gain_mem_q[0];
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = DwellLd;
          end else begin
            // Code is cleared and the new channel's MSB trial is applied in the same step.
            state_d = StDcSar;
            ch_d    = ch_nxt;
            led_d   = N_CH'(1) << ch_nxt;
            bit_d   = BitMsb;
            dac_d   = DacMsb;
            gain_d  = '0;
            cnt_d   = SettleLd;
          end
        end
        StRun: begin
          if (settled) begin
            // Last dwell cycle of the slot: emit the sample, then advance round-robin.
            sample_valid_c = 1'b1;
            ch_d           = ch_nxt;
            led_d          = N_CH'(1) << ch_nxt;
            dac_d          = dc_mem_q[ch_nxt];
            gain_d         = gain_mem_q[ch_nxt];
            cnt_d          = DwellLd;
          end
        end
        default: begin
          state_d = StIdle;
          ch_d    = '0;
          bit_d   = '0;
          dac_d   = '0;
          gain_d  = '0;
          led_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          fail_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      bit_q     <= '0;
      dac_q     <= '0;
      gain_q    <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= '0;
      cnt_q     <= '0;
      fs_q      <= 1'b0;
      fs_prev_q <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        dc_mem_q[i]   <= '0;
        gain_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      dac_q      <= dac_d;
      gain_q     <= gain_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      cnt_q      <= cnt_d;
      fs_q       <= fe_io.Find_Setting;
      fs_prev_q  <= fs_q;
      dc_mem_q   <= dc_mem_d;
      gain_mem_q <= gain_mem_d;
    end
  end

  assign fe_io.LED          = led_q;
  assign fe_io.DC_Comp      = dac_q;
  assign fe_io.PGA_Gain     = gain_q;
  assign fe_io.busy         = busy_q;
  assign fe_io.cal_done     = done_q;
  assign fe_io.cal_fail     = fail_q;
  assign fe_io.sample_valid = sample_valid_c;
  assign fe_io.sample_ch    = sample_valid_c ? ch_q : '0;
  assign fe_io.sample_data  = sample_valid_c ? fe_io.ADC : '0;

endmodule
